// File: rtl/complex_mult_core.sv
// Full-precision signed complex multiplier: (a_i + j*a_q) * (b_i + j*b_q).
// Latency 3 cycles (input regs -> product regs -> sum/difference regs), one result per cycle.
// No backpressure: the pipeline advances every cycle and dout_valid tracks din_valid.
module complex_mult_core #(
   parameter int  DINA_WIDTH = 8,
   parameter int  DINB_WIDTH = 8,
   localparam int MULT_WIDTH = DINA_WIDTH + DINB_WIDTH + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         din_valid,
   input  logic signed [DINA_WIDTH-1:0] dina_i,
   input  logic signed [DINA_WIDTH-1:0] dina_q,
   input  logic signed [DINB_WIDTH-1:0] dinb_i,
   input  logic signed [DINB_WIDTH-1:0] dinb_q,
   output logic                         dout_valid,
   output logic signed [MULT_WIDTH-1:0] mult_i,
   output logic signed [MULT_WIDTH-1:0] mult_q
);

   // A product of two signed values needs exactly the sum of the operand widths;
   // one extra bit on the final add/subtract absorbs the carry, so no value is lost
   // even with every operand at its most-negative value.
   localparam int PROD_WIDTH = DINA_WIDTH + DINB_WIDTH;

   logic signed [DINA_WIDTH-1:0] a_i_r;
   logic signed [DINA_WIDTH-1:0] a_q_r;
   logic signed [DINB_WIDTH-1:0] b_i_r;
   logic signed [DINB_WIDTH-1:0] b_q_r;

   logic signed [PROD_WIDTH-1:0] p_ii;
   logic signed [PROD_WIDTH-1:0] p_qq;
   logic signed [PROD_WIDTH-1:0] p_iq;
   logic signed [PROD_WIDTH-1:0] p_qi;

   logic signed [MULT_WIDTH-1:0] p_ii_x;
   logic signed [MULT_WIDTH-1:0] p_qq_x;
   logic signed [MULT_WIDTH-1:0] p_iq_x;
   logic signed [MULT_WIDTH-1:0] p_qi_x;

   logic [1:0] vld_sr;

   // Stage 1: capture operands every cycle; validity travels separately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_i_r <= '0;
         a_q_r <= '0;
         b_i_r <= '0;
         b_q_r <= '0;
      end else begin
         a_i_r <= dina_i;
         a_q_r <= dina_q;
         b_i_r <= dinb_i;
         b_q_r <= dinb_q;
      end
   end

   // Stage 2: the four partial products, signed at full product width.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_ii <= '0;
         p_qq <= '0;
         p_iq <= '0;
         p_qi <= '0;
      end else begin
         p_ii <= a_i_r * b_i_r;
         p_qq <= a_q_r * b_q_r;
         p_iq <= a_i_r * b_q_r;
         p_qi <= a_q_r * b_i_r;
      end
   end

   // Sign-extend each product by one bit ahead of the add/subtract.
   always_comb begin
      p_ii_x = {p_ii[PROD_WIDTH-1], p_ii};
      p_qq_x = {p_qq[PROD_WIDTH-1], p_qq};
      p_iq_x = {p_iq[PROD_WIDTH-1], p_iq};
      p_qi_x = {p_qi[PROD_WIDTH-1], p_qi};
   end

   // Stage 3: real part is the difference, imaginary part the sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mult_i <= '0;
         mult_q <= '0;
      end else begin
         mult_i <= p_ii_x - p_qq_x;
         mult_q <= p_iq_x + p_qi_x;
      end
   end

   // Valid shift register matching the three data stages; reset drops in-flight results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr     <= '0;
         dout_valid <= 1'b0;
      end else begin
         vld_sr     <= {vld_sr[0], din_valid};
         dout_valid <= vld_sr[1];
      end
   end

endmodule

// File: tb/tb_complex_mult_core.sv
// Directed and random checks of complex_mult_core against hand-computed products.
// Expected results are delayed through a 3-deep expectation line and compared each cycle.
// Includes async reset with results in flight and post-reset latency.
module tb_complex_mult_core;

   logic               clk;
   logic               rst_n;
   logic               din_valid;
   logic signed [7:0]  dina_i;
   logic signed [7:0]  dina_q;
   logic signed [7:0]  dinb_i;
   logic signed [7:0]  dinb_q;
   logic               dout_valid;
   logic signed [16:0] mult_i;
   logic signed [16:0] mult_q;

   int n_assert = 0;
   int n_fail   = 0;
   int n_in     = 0;
   int n_out    = 0;

   // expectation line: index 2 is what the outputs must show now
   logic mv [3];
   int   mi [3];
   int   mq [3];

   complex_mult_core dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_valid  (din_valid),
      .dina_i     (dina_i),
      .dina_q     (dina_q),
      .dinb_i     (dinb_i),
      .dinb_q     (dinb_q),
      .dout_valid (dout_valid),
      .mult_i     (mult_i),
      .mult_q     (mult_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int k = 0; k < 3; k++) begin
         mv[k] = 1'b0;
         mi[k] = 0;
         mq[k] = 0;
      end
   endtask

   // Drive one cycle of inputs, advance to the next falling edge, check outputs.
   task automatic step(input logic v, input int ai, input int aq, input int bi, input int bq,
                       input int ei, input int eq, input string tag);
      din_valid = v;
      dina_i    = 8'(ai);
      dina_q    = 8'(aq);
      dinb_i    = 8'(bi);
      dinb_q    = 8'(bq);
      if (v) n_in++;
      @(negedge clk);
      mv[2] = mv[1]; mi[2] = mi[1]; mq[2] = mq[1];
      mv[1] = mv[0]; mi[1] = mi[0]; mq[1] = mq[0];
      mv[0] = v;     mi[0] = ei;    mq[0] = eq;
      if (dout_valid === 1'b1) n_out++;
      chk({tag, " dout_valid"}, int'(dout_valid), int'(mv[2]));
      if (mv[2]) begin
         chk({tag, " mult_i"}, int'(mult_i), mi[2]);
         chk({tag, " mult_q"}, int'(mult_q), mq[2]);
      end
   endtask

   task automatic idle(input int n, input string tag);
      for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 0, 0, 0, tag);
   endtask

   initial begin
      int ai, aq, bi, bq;
      logic v;

      clear_model();
      rst_n     = 1'b0;
      din_valid = 1'b0;
      dina_i    = '0;
      dina_q    = '0;
      dinb_i    = '0;
      dinb_q    = '0;
      #1;
      chk("reset dout_valid", int'(dout_valid), 0);
      chk("reset mult_i", int'(mult_i), 0);
      chk("reset mult_q", int'(mult_q), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // single transaction, then gap so dout_valid must drop again
      step(1'b1, 4, 4, 4, 4, 0, 32, "a44b44");
      idle(4, "gap1");

      // directed vectors with hand-computed results
      step(1'b1, 15, 4, 4, 15, 0, 241, "a15_4");
      step(1'b1, 7, 5, 5, 7, 0, 74, "a7_5");
      step(1'b1, -128, -128, -128, -128, 0, 32768, "allneg");
      step(1'b1, -128, 127, -128, -128, 32640, 128, "neg_pos");
      step(1'b1, 3, -2, 5, 7, 29, 11, "mixed");
      step(1'b1, 127, 127, 127, -128, 32385, -127, "maxpos");
      idle(4, "gap2");

      // back-to-back sweep, continuous valid
      for (int i = 4; i <= 15; i++)
         for (int j = 4; j <= 15; j++)
            step(1'b1, i, j, j, i, 0, i*i + j*j, "sweep");
      idle(4, "gap3");

      // random operands with random valid
      n_in  = 0;
      n_out = 0;
      for (int k = 0; k < 300; k++) begin
         ai = int'($urandom_range(0, 255)) - 128;
         aq = int'($urandom_range(0, 255)) - 128;
         bi = int'($urandom_range(0, 255)) - 128;
         bq = int'($urandom_range(0, 255)) - 128;
         v  = 1'($urandom_range(0, 1));
         step(v, ai, aq, bi, bq, ai*bi - aq*bq, ai*bq + aq*bi, "rand");
      end
      idle(4, "flush");
      chk("rand valid count", n_out, n_in);

      // async reset: result A on outputs, B and C in flight
      step(1'b1, 10, 20, 30, 40, -500, 1000, "rstA");
      step(1'b1, 5, 6, 7, 8, -13, 82, "rstB");
      step(1'b1, 9, 9, 9, 9, 0, 162, "rstC");
      din_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst dout_valid", int'(dout_valid), 0);
      chk("async rst mult_i", int'(mult_i), 0);
      chk("async rst mult_q", int'(mult_q), 0);
      clear_model();
      @(negedge clk);
      @(negedge clk);
      chk("held rst dout_valid", int'(dout_valid), 0);
      rst_n = 1'b1;
      idle(5, "post_rst");

      // first transaction after reset keeps the standard latency
      step(1'b1, -1, 2, 3, -4, 5, 10, "after_rst");
      idle(4, "end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
